irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchroniser flops on each ext_irq_i bit; legal range 2..3.
REQ-002 Port clk, input, 1: single system clock shared with the CPU, ROM and data RAM.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port ce, input, 1: register-file select from the data bus address decode.
REQ-005 Port we, input, 1: write strobe, valid only when ce=1.
REQ-006 Port addr, input, 32: byte address; only addr[4:2] is decoded.
REQ-007 Port sel, input, 4: byte enables; only sel[0] gates writes.
REQ-008 Port data_i, input, 32: write data; only bits [5:0] are used.
REQ-009 Port data_o, output, 32: read data.
REQ-010 Port timer_int_i, input, 1: CP0 timer interrupt, already clk-synchronous, maps to source 0.
REQ-011 Port ext_irq_i, input, 5: asynchronous external lines, mapped to sources 5:1.
REQ-012 Port int_o, output, 6: registered interrupt vector to the CPU int_i input.

Function
REQ-013 Source 0 SHALL bypass synchronisation; each ext_irq_i bit SHALL pass through a SYNC_STAGES-deep flop chain.
REQ-014 The adjusted level SHALL be adj[i] = src[i] XOR POL[i].
REQ-015 A prev register SHALL hold adj from the previous cycle; edge[i] = adj[i] AND NOT prev[i].
REQ-016 The register map at addr[4:2] SHALL be:
- 0 RAW (RO) = adj
- 1 EN (RW)
- 2 MODE (RW; 1 = edge, 0 = level)
- 3 POL (RW; 1 = active-low)
- 4 PEND (R/W1C)
- 5 ACT (RO) = PEND AND EN
- 6..7 read 0; writes to them are ignored.
REQ-017 A write SHALL occur on a clk edge with ce=1, we=1 and sel[0]=1; when sel[0]=0 the write SHALL be dropped.
REQ-018 Reads SHALL be combinational: data_o = {26'b0, reg[5:0]} when ce=1 and we=0, otherwise 32'h0.
REQ-019 In level mode, PEND[i] SHALL be registered as adj[i] every cycle, and W1C SHALL have no effect.
REQ-020 In edge mode, PEND[i] SHALL set on edge[i] and clear on a W1C write of 1; when both occur in the same cycle, set SHALL win.
REQ-021 int_o SHALL be registered as PEND AND EN, one cycle after PEND changes.
REQ-022 Latency for timer_int_i high before edge k SHALL be: PEND at edge k, int_o at edge k+1.
REQ-023 For ext_irq_i, SYNC_STAGES SHALL be added to the timer latency: with SYNC_STAGES=2, a line high before edge k gives PEND at edge k+2 and int_o at edge k+3.
REQ-024 Writing POL or MODE SHALL take effect the next cycle; a resulting edge on adj SHALL set PEND like any other edge (software clears it).
REQ-025 Clearing EN[i] SHALL drop int_o[i] one cycle later without altering PEND[i].
REQ-026 A held-high edge-mode source SHALL set PEND only once until it deasserts and reasserts.

Reset
REQ-027 While rst=1 at a clk edge, EN, MODE, POL, PEND, prev, all synchroniser flops and int_o SHALL be cleared to 0.
REQ-028 Reset asserted mid-operation SHALL drop int_o to 0 at that edge; bus writes in reset cycles SHALL be ignored.
REQ-029 After reset release, a source already high SHALL be treated as a new edge, because prev=0 after reset.
REQ-030 data_o SHALL remain combinational during reset and read the cleared values.

Verification
REQ-031 Reset, then EN=6'h01 and MODE=0; raise timer_int_i before edge k -> PEND[0]=1 at k and int_o=6'h01 at k+1; lower it -> int_o=0 two edges later.
REQ-032 Write EN=6'h02 and MODE=6'h02; pulse ext_irq_i[0] for 3 cycles -> PEND=6'h02 and int_o=6'h02 three edges after the rise; hold the line -> no re-set after W1C; W1C 6'h02 -> int_o=0.
REQ-033 In edge mode, issue a W1C of PEND[1] in the same cycle a new edge arrives -> PEND[1] stays 1.
REQ-034 Write POL=6'h04 with ext_irq_i[1]=0 and EN=6'h04 -> RAW=6'h04 and int_o[2]=1 within 2 edges; drive the line high -> int_o[2]=0.
REQ-035 Write with sel=4'b1110 -> registers unchanged; read addr 0x18 -> 32'h0; read with ce=0 -> 32'h0.
REQ-036 With int_o=6'h3F, assert rst for 1 cycle -> int_o=0 at that edge and all registers read 0; a held source re-pends after release.

Source files
------------

// File: rtl/irq_ctrl.sv
// Six-source interrupt controller: synchronises external lines, applies polarity,
// latches level/edge pending state and drives a registered interrupt vector.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        timer_int_i,
  input  logic [4:0]  ext_irq_i,
  output logic [5:0]  int_o
);

  localparam logic [2:0] REG_RAW  = 3'd0;
  localparam logic [2:0] REG_EN   = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_POL  = 3'd3;
  localparam logic [2:0] REG_PEND = 3'd4;
  localparam logic [2:0] REG_ACT  = 3'd5;

  logic [4:0] sync_q [SYNC_STAGES];
  logic [5:0] en, mode, pol, pend, prev;
  logic [5:0] src, adj, rise, w1c, pend_next, rd_val;
  logic [2:0] reg_sel;
  logic       wr;
  logic       unused;

  assign unused  = ^{addr[31:5], addr[1:0], sel[3:1], data_i[31:6]};
  assign reg_sel = addr[4:2];
  assign wr      = ce & we & sel[0];

  // Timer is already clk-synchronous and skips the synchroniser chain.
  assign src  = {sync_q[SYNC_STAGES-1], timer_int_i};
  assign adj  = src ^ pol;
  assign rise = adj & ~prev;
  assign w1c  = (wr && reg_sel == REG_PEND) ? data_i[5:0] : 6'h00;

  // Edge mode: a new edge outranks a same-cycle W1C so no event is lost.
  assign pend_next = (~mode & adj) | (mode & (rise | (pend & ~w1c)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 5'h00;
    end else begin
      sync_q[0] <= ext_irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 6'h00;
      mode  <= 6'h00;
      pol   <= 6'h00;
      pend  <= 6'h00;
      prev  <= 6'h00;
      int_o <= 6'h00;
    end else begin
      pend  <= pend_next;
      prev  <= adj;
      int_o <= pend & en;
      if (wr) begin
        case (reg_sel)
          REG_EN:   en   <= data_i[5:0];
          REG_MODE: mode <= data_i[5:0];
          REG_POL:  pol  <= data_i[5:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = 6'h00;
    case (reg_sel)
      REG_RAW:  rd_val = adj;
      REG_EN:   rd_val = en;
      REG_MODE: rd_val = mode;
      REG_POL:  rd_val = pol;
      REG_PEND: rd_val = pend;
      REG_ACT:  rd_val = pend & en;
      default:  rd_val = 6'h00;
    endcase
  end

  assign data_o = (ce && !we) ? {26'h0, rd_val} : 32'h0;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl; a reference model queues the expected
// int_o every cycle and the expected data_o for every read, and a monitor compares them.
module tb_irq_ctrl;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, ce, we, timer_int_i;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;
  logic [4:0]  ext_irq_i;
  logic [5:0]  int_o;

  logic        t_val;
  logic [4:0]  e_val;

  // Reference model state
  logic [5:0]  m_en, m_mode, m_pol, m_pend, m_prev;
  logic [4:0]  m_hist[$];

  logic [5:0]  exp_int_q[$];
  logic [31:0] exp_rd_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .timer_int_i(timer_int_i),
    .ext_irq_i(ext_irq_i), .int_o(int_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [5:0] model_raw();
    return {m_hist[0], timer_int_i} ^ m_pol;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {26'h0, model_raw()};
      3'd1:    return {26'h0, m_en};
      3'd2:    return {26'h0, m_mode};
      3'd3:    return {26'h0, m_pol};
      3'd4:    return {26'h0, m_pend};
      3'd5:    return {26'h0, m_pend & m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0;
    m_hist = {};
    for (int i = 0; i < S; i++) m_hist.push_back(5'h00);
  endtask

  task automatic model_edge();
    logic [5:0] adj, w1c, nxt, next_int;
    logic       wr;
    adj = model_raw();
    if (rst) begin
      model_clear();
      exp_int_q.push_back(6'h00);
    end else begin
      wr  = ce && we && sel[0];
      w1c = (wr && addr[4:2] == 3'd4) ? data_i[5:0] : 6'h00;
      for (int i = 0; i < 6; i++) begin
        if (!m_mode[i])                nxt[i] = adj[i];
        else if (adj[i] && !m_prev[i]) nxt[i] = 1'b1;
        else if (w1c[i])               nxt[i] = 1'b0;
        else                           nxt[i] = m_pend[i];
      end
      next_int = m_pend & m_en;
      m_pend   = nxt;
      m_prev   = adj;
      if (wr) begin
        case (addr[4:2])
          3'd1:    m_en   = data_i[5:0];
          3'd2:    m_mode = data_i[5:0];
          3'd3:    m_pol  = data_i[5:0];
          default: ;
        endcase
      end
      // External lines appear S edges after they are sampled.
      m_hist.push_back(ext_irq_i);
      void'(m_hist.pop_front());
      exp_int_q.push_back(next_int);
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [5:0]  ei;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (exp_int_q.size() > 0) begin
        ei = exp_int_q.pop_front();
        checks++;
        if (int_o !== ei) begin
          errors++;
          $display("FAIL int_o t=%0t got %h expected %h", $time, int_o, ei);
        end
      end
      if (exp_rd_q.size() > 0) begin
        er = exp_rd_q.pop_front();
        checks++;
        if (data_o !== er) begin
          errors++;
          $display("FAIL data_o t=%0t addr=%h ce=%b got %h expected %h",
                   $time, addr, ce, data_o, er);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
    ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
    timer_int_i = t_val;
    ext_irq_i   = e_val;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_reg(input int a, input logic [5:0] d, input logic [3:0] s);
    step();
    ce = 1'b1; we = 1'b1; sel = s;
    addr   = ($urandom() & 32'hFFFF_FFE3) | (32'(a) << 2);
    data_i = ($urandom() & 32'hFFFF_FFC0) | {26'h0, d};
  endtask

  task automatic rd_reg(input int a);
    logic [2:0] a3;
    a3 = a[2:0];
    step();
    ce = 1'b1; we = 1'b0; sel = 4'($urandom_range(0, 15));
    addr = ($urandom() & 32'hFFFF_FFE3) | (32'(a) << 2);
    exp_rd_q.push_back(model_read(a3));
  endtask

  task automatic rd_noce(input int a);
    step();
    ce = 1'b0; we = 1'($urandom_range(0, 1)); sel = 4'hF;
    addr = 32'(a) << 2;
    exp_rd_q.push_back(32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, b;
    rst = 1'b1; ce = 0; we = 0; addr = '0; sel = '0; data_i = '0;
    t_val = 0; e_val = '0; timer_int_i = 0; ext_irq_i = '0;
    idle(2);
    rd_reg(1);
    rd_reg(4);
    rst = 1'b0;

    // Timer source, level mode
    wr_reg(1, 6'h01, 4'h1);
    wr_reg(2, 6'h00, 4'h1);
    idle(2);
    t_val = 1; step();
    rd_reg(4); rd_reg(5); idle(2);
    t_val = 0; idle(3); rd_reg(4);

    // ext_irq_i[0] in edge mode, held high then W1C
    wr_reg(1, 6'h02, 4'h1);
    wr_reg(2, 6'h02, 4'h1);
    e_val = 5'h01; idle(3);
    rd_reg(4); idle(2);
    wr_reg(4, 6'h02, 4'h1);
    idle(3); rd_reg(4); rd_reg(0);

    // W1C in the same cycle a new edge arrives
    e_val = 5'h00; idle(4);
    e_val = 5'h01; step(); step();
    wr_reg(4, 6'h02, 4'h1);
    rd_reg(4); idle(2); rd_reg(4);

    // Polarity inversion on source 2
    e_val = 5'h00;
    wr_reg(3, 6'h04, 4'h1);
    wr_reg(1, 6'h04, 4'h1);
    rd_reg(0); idle(3); rd_reg(5);
    e_val = 5'h02; idle(5); rd_reg(0);

    // Byte enable gating, unmapped and deselected reads
    wr_reg(1, 6'h3F, 4'b1110);
    wr_reg(3, 6'h00, 4'b1110);
    rd_reg(1); rd_reg(3); rd_reg(6); rd_reg(7); rd_noce(1); rd_noce(4);

    // All sources active, then a mid-operation reset
    wr_reg(3, 6'h00, 4'h1);
    wr_reg(2, 6'h00, 4'h1);
    wr_reg(1, 6'h3F, 4'h1);
    t_val = 1; e_val = 5'h1F; idle(6);
    rst = 1'b1;
    rd_reg(1); rd_reg(4);
    wr_reg(1, 6'h15, 4'h1);
    rst = 1'b0;
    rd_reg(1); rd_reg(2);
    wr_reg(2, 6'h3F, 4'h1);
    wr_reg(1, 6'h3F, 4'h1);
    idle(4); rd_reg(4); rd_reg(5);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) t_val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 4);
        e_val[b] = ~e_val[b];
      end
      op = $urandom_range(0, 40);
      if (op < 14)
        wr_reg($urandom_range(0, 7), 6'($urandom_range(0, 63)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h1);
      else if (op < 28) rd_reg($urandom_range(0, 7));
      else if (op < 32) rd_noce($urandom_range(0, 7));
      else if (op < 40) step();
      else begin
        rst = 1'b1;
        wr_reg($urandom_range(1, 4), 6'($urandom_range(0, 63)), 4'h1);
        rst = 1'b0;
      end
    end

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
